// File: rtl/mem_ls_pkg.sv
// Shared encodings and the alignment check for the load/store initiator.
package mem_ls_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    ERR,
    RESP
  } state_t;

  // Halfwords need an even address and words need a 4-byte aligned address.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    return ((size == SZ_HALF) && lane[0]) || ((size == SZ_WORD) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/mem_ls_lane.sv
// Lane extraction with sign/zero extension for loads, and lane merge of new
// store data into a word read back from memory for sub-word stores.
module mem_ls_lane
  import mem_ls_pkg::*;
(
  input  logic [31:0] rd,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Pick the addressed lane out of the word and extend it to 32 bits.
  always_comb begin
    rd_byte   = rd[{lane, 3'b000} +: 8];
    rd_half   = rd[{lane[1], 4'b0000} +: 16];
    load_data = 32'h0;
    case (size)
      SZ_BYTE: load_data = {{24{sgn & rd_byte[7]}}, rd_byte};
      SZ_HALF: load_data = {{16{sgn & rd_half[15]}}, rd_half};
      SZ_WORD: load_data = rd;
      default: load_data = 32'h0;
    endcase
  end

  // Overwrite only the addressed lane; the rest of the word is preserved.
  always_comb begin
    merge_data = rd;
    case (size)
      SZ_BYTE: merge_data[{lane, 3'b000} +: 8]     = wdata[7:0];
      SZ_HALF: merge_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      SZ_WORD: merge_data = wdata;
      default: merge_data = rd;
    endcase
  end

endmodule

// File: rtl/mem_ls_initiator.sv
// Load/store initiator between the MEM stage and a word-wide data memory.
// Sub-word stores are done as read-modify-write since the memory always
// writes a full word. Define MEM_LS_STATS_EN to add saturating counters.
//
// state  | meaning
// IDLE   | ready for a request; latches it on accept
// LOAD   | aligned address on memory, capture and extend the lane
// RMW_RD | aligned address on memory, merge new data into the read word
// WRITE  | mem_we high for this single cycle
// ERR    | misaligned or illegal size, no memory access
// RESP   | response held until resp_ready
module mem_ls_initiator
  import mem_ls_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int BYTE_SIZE  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wd,
  input  logic [31:0]           mem_rd
`ifdef MEM_LS_STATS_EN
  ,
  output logic [15:0]           stat_loads,
  output logic [15:0]           stat_stores,
  output logic [15:0]           stat_errs
`endif
);

  if (BYTE_SIZE != 4) begin : g_bad_byte_size
    $error("mem_ls_initiator: BYTE_SIZE must be 4");
  end

  state_t      state;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic [1:0]  lat_lane;
  logic [31:0] lat_wdata;
  logic        mem_we_q;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  mem_ls_lane u_lane (
    .rd         (mem_rd),
    .lane       (lat_lane),
    .size       (lat_size),
    .sgn        (lat_signed),
    .wdata      (lat_wdata),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // Reset must never coincide with a memory write, even mid-WRITE.
  assign mem_we = mem_we_q & rst_n;

  // Request sequencing with registered handshake and memory outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr   <= '0;
      mem_wd     <= 32'h0;
      lat_size   <= SZ_BYTE;
      lat_signed <= 1'b0;
      lat_lane   <= 2'b00;
      lat_wdata  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready  <= 1'b0;
            lat_size   <= req_size;
            lat_signed <= req_signed;
            lat_lane   <= req_addr[1:0];
            lat_wdata  <= req_wdata;
            mem_addr   <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            if ((req_size == 2'b11) || misaligned(req_size, req_addr[1:0])) begin
              state <= ERR;
            end else if (!req_we) begin
              state <= LOAD;
            end else if (req_size == SZ_WORD) begin
              mem_wd   <= req_wdata;
              mem_we_q <= 1'b1;
              state    <= WRITE;
            end else begin
              state <= RMW_RD;
            end
          end
        end
        LOAD: begin
          resp_rdata <= load_data;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RMW_RD: begin
          mem_wd   <= merge_data;
          mem_we_q <= 1'b1;
          state    <= WRITE;
        end
        WRITE: begin
          mem_we_q   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        ERR: begin
          resp_err   <= 1'b1;
          resp_rdata <= 32'h0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_LS_STATS_EN
  logic stat_we_q;

  // Count completed transactions by type; errors only count as errors.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_we_q   <= 1'b0;
      stat_loads  <= 16'h0;
      stat_stores <= 16'h0;
      stat_errs   <= 16'h0;
    end else begin
      if ((state == IDLE) && req_valid) begin
        stat_we_q <= req_we;
      end
      if ((state == RESP) && resp_ready) begin
        if (resp_err) begin
          if (stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'h1;
        end else if (stat_we_q) begin
          if (stat_stores != 16'hFFFF) stat_stores <= stat_stores + 16'h1;
        end else begin
          if (stat_loads != 16'hFFFF) stat_loads <= stat_loads + 16'h1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_ls_initiator.sv
// Directed bench for mem_ls_initiator with a byte-array memory model.
module tb_mem_ls_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
`ifdef MEM_LS_STATS_EN
  logic [15:0] stat_loads;
  logic [15:0] stat_stores;
  logic [15:0] stat_errs;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:4095];
  logic       preload;

  int          r_lat;
  int          r_we_cnt;
  int          r_we_cyc;
  logic [11:0] r_we_addr;
  logic [31:0] r_we_wd;
  logic [31:0] r_rdata;
  logic        r_err;

  mem_ls_initiator #(.ADDR_WIDTH(12), .BYTE_SIZE(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
`ifdef MEM_LS_STATS_EN
    ,
    .stat_loads  (stat_loads),
    .stat_stores (stat_stores),
    .stat_errs   (stat_errs)
`endif
  );

  always #5 clk = ~clk;

  assign mem_rd = {mem[{mem_addr[11:2], 2'b11}], mem[{mem_addr[11:2], 2'b10}],
                   mem[{mem_addr[11:2], 2'b01}], mem[{mem_addr[11:2], 2'b00}]};

  // Memory model: preload once, then full-word writes on mem_we.
  always @(posedge clk) begin
    if (preload) begin
      mem[12'h010] <= 8'h11;
      mem[12'h011] <= 8'h22;
      mem[12'h012] <= 8'h83;
      mem[12'h013] <= 8'h44;
    end else if (mem_we) begin
      mem[{mem_addr[11:2], 2'b00}] <= mem_wd[7:0];
      mem[{mem_addr[11:2], 2'b01}] <= mem_wd[15:8];
      mem[{mem_addr[11:2], 2'b10}] <= mem_wd[23:16];
      mem[{mem_addr[11:2], 2'b11}] <= mem_wd[31:24];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request and follow it until resp_valid (bounded).
  task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [11:0] addr, input logic [31:0] wdata);
    int n;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n         = 1;
    r_we_cnt  = 0;
    r_we_cyc  = 0;
    r_we_addr = '0;
    r_we_wd   = '0;
    while (!resp_valid && n < 10) begin
      if (mem_we) begin
        r_we_cnt++;
        r_we_cyc  = n;
        r_we_addr = mem_addr;
        r_we_wd   = mem_wd;
      end
      @(posedge clk); #1;
      n++;
    end
    if (!resp_valid) chk("resp_timeout", 32'(resp_valid), 32'd1);
    r_lat   = n;
    r_rdata = resp_rdata;
    r_err   = resp_err;
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  function automatic logic [31:0] mem_word10();
    return {mem[12'h013], mem[12'h012], mem[12'h011], mem[12'h010]};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    preload    = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    @(posedge clk); #1;
    preload = 1'b0;
    @(posedge clk); #1;

    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wd", mem_wd, 32'h0);
`ifdef MEM_LS_STATS_EN
    chk("rst_stat_loads", 32'(stat_loads), 32'd0);
    chk("rst_stat_errs", 32'(stat_errs), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Signed byte load at 0x12
    run_req(1'b0, 2'b00, 1'b1, 12'h012, 32'h0);
    chk("lb_data", r_rdata, 32'hFFFFFF83);
    chk("lb_lat", 32'(r_lat), 32'd2);
    chk("lb_err", 32'(r_err), 32'd0);
    chk("lb_we", 32'(r_we_cnt), 32'd0);
    finish_resp();
    chk("lb_ready_after", 32'(req_ready), 32'd1);

    // Unsigned byte load at 0x12
    run_req(1'b0, 2'b00, 1'b0, 12'h012, 32'h0);
    chk("lbu_data", r_rdata, 32'h00000083);
    finish_resp();

    // Unsigned half load at 0x12
    run_req(1'b0, 2'b01, 1'b0, 12'h012, 32'h0);
    chk("lhu_data", r_rdata, 32'h00004483);
    chk("lhu_lat", 32'(r_lat), 32'd2);
    finish_resp();

    // Signed word load at 0x10
    run_req(1'b0, 2'b10, 1'b1, 12'h010, 32'h0);
    chk("lw_data", r_rdata, 32'h44832211);
    finish_resp();

    // Byte store 0xAB at 0x11
    run_req(1'b1, 2'b00, 1'b0, 12'h011, 32'h000000AB);
    chk("sb_we_cnt", 32'(r_we_cnt), 32'd1);
    chk("sb_we_cyc", 32'(r_we_cyc), 32'd2);
    chk("sb_we_addr", 32'(r_we_addr), 32'h010);
    chk("sb_we_wd", r_we_wd, 32'h4483AB11);
    chk("sb_lat", 32'(r_lat), 32'd3);
    chk("sb_rdata", r_rdata, 32'h0);
    chk("sb_err", 32'(r_err), 32'd0);
    finish_resp();

    run_req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    chk("lw_after_sb", r_rdata, 32'h4483AB11);
    finish_resp();

    // Misaligned half load at 0x13
    run_req(1'b0, 2'b01, 1'b0, 12'h013, 32'h0);
    chk("mis_lh_err", 32'(r_err), 32'd1);
    chk("mis_lh_rdata", r_rdata, 32'h0);
    chk("mis_lh_lat", 32'(r_lat), 32'd2);
    chk("mis_lh_we", 32'(r_we_cnt), 32'd0);
    finish_resp();

    // Misaligned word store at 0x12
    run_req(1'b1, 2'b10, 1'b0, 12'h012, 32'hCAFEF00D);
    chk("mis_sw_err", 32'(r_err), 32'd1);
    chk("mis_sw_rdata", r_rdata, 32'h0);
    chk("mis_sw_lat", 32'(r_lat), 32'd2);
    chk("mis_sw_we", 32'(r_we_cnt), 32'd0);
    finish_resp();

    // Illegal size
    run_req(1'b0, 2'b11, 1'b0, 12'h010, 32'h0);
    chk("ill_sz_err", 32'(r_err), 32'd1);
    finish_resp();
    chk("mem_after_errs", mem_word10(), 32'h4483AB11);

    // Response back-pressure with a stray request in the window
    run_req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 12'h010;
        req_wdata = 32'hDEADBEEF;
        req_valid = 1'b1;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("stall_valid", 32'(resp_valid), 32'd1);
      chk("stall_rdata", resp_rdata, 32'h4483AB11);
      chk("stall_ready", 32'(req_ready), 32'd0);
    end
    finish_resp();
    for (int k = 0; k < 3; k++) begin
      chk("stall_no_accept_we", 32'(mem_we), 32'd0);
      @(posedge clk); #1;
      chk("stall_no_resp", 32'(resp_valid), 32'd0);
    end
    chk("stall_mem", mem_word10(), 32'h4483AB11);

`ifdef MEM_LS_STATS_EN
    chk("stat_loads", 32'(stat_loads), 32'd6);
    chk("stat_stores", 32'(stat_stores), 32'd1);
    chk("stat_errs", 32'(stat_errs), 32'd3);
`endif

    // Reset during WRITE of a half store
    req_we     = 1'b1;
    req_size   = 2'b01;
    req_signed = 1'b0;
    req_addr   = 12'h010;
    req_wdata  = 32'h00001234;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rw_rmw_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    chk("rw_write_we", 32'(mem_we), 32'd1);
    chk("rw_write_wd", mem_wd, 32'h44831234);
    rst_n = 1'b0;
    #1;
    chk("rw_gated_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rw_idle_ready", 32'(req_ready), 32'd1);
    chk("rw_no_resp", 32'(resp_valid), 32'd0);
    chk("rw_mem", mem_word10(), 32'h4483AB11);
`ifdef MEM_LS_STATS_EN
    chk("rw_stat_loads", 32'(stat_loads), 32'd0);
    chk("rw_stat_stores", 32'(stat_stores), 32'd0);
    chk("rw_stat_errs", 32'(stat_errs), 32'd0);
`endif
    @(posedge clk); #1;
    chk("rw_still_idle", 32'(resp_valid), 32'd0);
    chk("rw_no_write", 32'(mem_we), 32'd0);

    run_req(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    chk("rw_load", r_rdata, 32'h4483AB11);
    finish_resp();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ls_initiator.md
Name: mem_ls_initiator

Overview:
- Load/store initiator that drives the byte-addressable, little-endian data memory: combinational read, write on the clock edge when WE is high, and always BYTE_SIZE bytes per access.
- Sits between the pipeline MEM stage and the data memory.
- Accepts byte, halfword and word requests over a valid/ready handshake.
- Performs aligned reads with sign or zero extension.
- Implements sub-word stores as read-modify-write, because the memory always writes the full word.

Parameters:
- ADDR_WIDTH, 12, byte-address width; must match the memory.
- BYTE_SIZE, 4, memory data width in bytes. Fixed at 4; any other value is a configuration error, flagged at elaboration.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is illegal
- req_signed  in  1  sign-extend sub-word loads
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed when resp_valid & resp_ready
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  misaligned address or illegal size
- mem_we  out  1  to memory WE
- mem_addr  out  ADDR_WIDTH  to memory ADDR; always word-aligned ({addr[ADDR_WIDTH-1:2], 2'b00})
- mem_wd  out  32  to memory WD
- mem_rd  in  32  from memory RD; combinational

Behaviour:
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, mem_we 0, mem_addr 0, mem_wd 0.
- States:
  - IDLE: req_ready = 1. On accept, latch the request. Next state:
    - ERR if the request is misaligned (half with addr[0] = 1; word with addr[1:0] != 0) or req_size = 11.
    - LOAD for a load.
    - WRITE for a word store.
    - RMW_RD for a byte or half store.
  - LOAD: mem_addr = aligned address. Capture mem_rd lane addr[1:0], extend per req_signed. Go to RESP.
  - RMW_RD: mem_addr = aligned address. Capture mem_rd into the merge register. Go to WRITE.
  - WRITE: mem_addr = aligned address.
    - mem_wd = req_wdata for a word store, otherwise the merged word with the new byte/half in its lane.
    - mem_we = 1 for exactly this one cycle. Go to RESP.
  - ERR: no memory access, mem_we stays 0. Go to RESP with resp_err = 1 and resp_rdata = 0.
  - RESP: resp_valid = 1. Outputs hold stable until resp_ready; on handshake go to IDLE.
- req_ready is 0 in every state except IDLE; only one request is outstanding at a time.
- Latency from accept edge T to resp_valid: T+2 for load, word store and error; T+3 for sub-word store.
- Lane extraction: byte = bits [8*a+7:8*a] with a = addr[1:0]; half = bits [16*addr[1]+15 : 16*addr[1]].
- mem_we is combinationally gated with rst_n: no memory write occurs on an edge where rst_n = 0.
- Reset in any state: next edge returns to IDLE and drops any latched request and pending response; no partial write.
- resp_ready high while not in RESP: ignored.
- Back-to-back requests: the next accept is possible in the cycle after the RESP handshake.

Optional Feature:
- Macro: MEM_LS_STATS_EN.
- Defined:
  - Adds outputs stat_loads, stat_stores, stat_errs, each 16 bits.
  - Saturating counters, incremented on the RESP handshake by type; an error counts only in stat_errs.
  - Reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mem_ls_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - state encoding IDLE, LOAD, RMW_RD, WRITE, ERR, RESP;
  - misalignment check function.
- Sub-module mem_ls_lane: purely combinational lane extract/extend and lane merge; instantiated once.

Test Plan:
- Preload for all scenarios: memory bytes 0x10..0x13 = 11 22 83 44.
- Signed byte load at 0x12 -> resp_rdata 0xFFFFFF83 at T+2, resp_err 0, mem_we never high.
- Unsigned half load at 0x12 -> 0x00004483; signed word load at 0x10 -> 0x44832211.
- Byte store 0xAB at 0x11:
  - mem_we high for exactly one cycle at T+2 with mem_addr 0x10 and mem_wd 0x4483AB11;
  - resp_valid at T+3;
  - a following word load at 0x10 returns 0x4483AB11.
- Misaligned half load at 0x13, then word store at 0x12 -> resp_err 1, resp_rdata 0, at T+2 each, mem_we 0 throughout.
- resp_ready held low 3 cycles -> resp_valid and data stable, req_ready 0. A req_valid pulse in that window is not accepted.
- rst_n low during WRITE of a half store -> mem_we 0 that cycle, memory unchanged, IDLE next cycle. With MEM_LS_STATS_EN defined, counters read 0.
